fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and hazard control for the pipelined CPU. It replaces the stateless forwarding logic with one block that does three things: it selects EX-stage operand bypasses for NUM_SRC source operands, it detects load-use hazards in ID and drives a multi-cycle stall/bubble sequence of LOAD_STALL cycles, and it keeps saturating statistics of forward and stall events. It sits between the ID/EX, EX/MEM and MEM/WB pipeline registers and the PC / IF/ID write enables.

## Interface
- REG_AW, 5, register address width
- NUM_SRC, 2, source operands per instruction (1..4); operand k uses bits [k*REG_AW +: REG_AW] of packed buses
- LOAD_STALL, 1, stall cycles inserted per load-use hazard (1..7)
- CNT_W, 16, statistics counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- id_src_addr_i  in  NUM_SRC*REG_AW  source register addresses of the instruction in ID
- id_src_used_i  in  NUM_SRC  operand k actually read by the ID instruction
- ex_src_addr_i  in  NUM_SRC*REG_AW  source addresses held in ID/EX
- idex_memread_i  in  1  instruction in EX is a load
- idex_rd_i  in  REG_AW  destination of the instruction in EX
- exmem_regwrite_i  in  1  EX/MEM RegWrite
- exmem_rd_i  in  REG_AW  EX/MEM destination (post RegDst mux)
- memwb_regwrite_i  in  1  MEM/WB RegWrite
- memwb_rd_i  in  REG_AW  MEM/WB destination
- flush_i  in  1  taken branch/jump flush this cycle
- clr_cnt_i  in  1  synchronous clear of statistics
- fwd_sel_o  out  2*NUM_SRC  per-operand mux select: 2'b10 EX/MEM, 2'b01 MEM/WB, 2'b00 register file
- pc_write_o  out  1  PC write enable
- ifid_write_o  out  1  IF/ID write enable
- idex_bubble_o  out  1  force ID/EX control fields to zero
- stall_busy_o  out  1  FSM is in STALL
- fwd_cnt_o  out  CNT_W  cycles with at least one nonzero forward select
- stall_cnt_o  out  CNT_W  cycles with a stall asserted

## Operation
- Forwarding is combinational and evaluated per operand k.
  - EX hit: exmem_regwrite_i && exmem_rd_i!=0 && exmem_rd_i==src_k. An EX hit gives 2'b10.
  - MEM hit: the same test on the MEM/WB signals. It gives 2'b01, but only when there is no EX hit.
  - Otherwise the select is 2'b00.
  - Register 0 is never forwarded.
- Load-use detection:
  - hit = idex_memread_i && idex_rd_i!=0 && (exists k: id_src_used_i[k] && id_src_k==idex_rd_i).
- FSM states are IDLE and STALL, with a 3-bit down-counter rem.
- Stall outputs: stall = (IDLE && hit && !flush_i) || (STALL && !flush_i).
  - While stall: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
  - Otherwise these outputs are 1, 1, 0.
- IDLE transitions:
  - hit && !flush_i && LOAD_STALL>1 → STALL with rem=LOAD_STALL-1.
  - Otherwise stay in IDLE.
- STALL behaviour:
  - ID/EX inputs are ignored, because they are bubbles.
  - rem decrements each cycle. The cycle with rem==1 is the last stall cycle, and the next state is IDLE.
  - flush_i → IDLE immediately, with no stall in that cycle.
  - After returning to IDLE, detection re-evaluates normally.
- Counters:
  - Both counters saturate at all-ones.
  - fwd_cnt_o increments by 1 per cycle in which any fwd_sel_o field is nonzero.
  - stall_cnt_o increments per cycle in which stall is 1.
  - clr_cnt_i has priority over increment and zeroes both counters at the next edge.

## Timing
- Reset values:
  - State IDLE, rem=0.
  - fwd_cnt_o=0 and stall_cnt_o=0.
  - stall_busy_o=0; pc_write_o=1, ifid_write_o=1, idex_bubble_o=0.
  - fwd_sel_o reflects its inputs immediately, because it is combinational.
- Forward selects and the stall outputs have zero latency and are valid in the same cycle as their inputs.
- A load-use hazard produces exactly LOAD_STALL consecutive stall cycles, beginning in the detection cycle.
- stall_busy_o is high for LOAD_STALL-1 cycles, starting one cycle after detection.
- flush_i and hit in the same cycle: flush wins, and there is no stall.
- Reset asserted mid-stall: return to IDLE asynchronously and release the stall outputs at once.
- Counter saturation: at all-ones, a further increment holds the value.

## Test plan
- **EX over MEM priority:** exmem rd=3/rw=1, memwb rd=3/rw=1, ex_src0=3, ex_src1=4 → fwd_sel_o=4'b0010. Then set exmem rw=0 → fwd_sel_o=4'b0001.
- **Register 0:** exmem rd=0/rw=1 and src=0 → fwd_sel_o=0, and fwd_cnt_o does not increment.
- **Load-use, LOAD_STALL=1:**
  - idex_memread=1, rd=5, id_src0=5 used → one cycle of pc_write=0 / bubble=1, stall_busy_o stays 0, stall_cnt_o=1.
  - Same stimulus with id_src_used=0 → no stall.
- **Load-use, LOAD_STALL=3:** a hit gives stall for 3 cycles, stall_busy_o high in cycles 2–3, then IDLE, and stall_cnt_o=3.
- **Flush:**
  - flush_i in stall cycle 2 (LOAD_STALL=3) → the stall drops that cycle, and the state is IDLE next.
  - hit and flush together → no stall.
- **Reset and counters:**
  - rst_i pulsed mid-stall → outputs return to their reset values without waiting for a clock edge.
  - With CNT_W=4, 20 forwarding cycles → fwd_cnt_o=15.
  - clr_cnt_i with a concurrent event → counters read 0.

Source files
------------

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle for fwd_hazard_unit: hazard inputs from the ID/EX, EX/MEM and
// MEM/WB registers plus the forwarding selects, stall controls and statistics it returns.
interface fwd_hazard_unit_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC*REG_AW-1:0] id_src_addr_i;
  logic [NUM_SRC-1:0]        id_src_used_i;
  logic [NUM_SRC*REG_AW-1:0] ex_src_addr_i;
  logic                      idex_memread_i;
  logic [REG_AW-1:0]         idex_rd_i;
  logic                      exmem_regwrite_i;
  logic [REG_AW-1:0]         exmem_rd_i;
  logic                      memwb_regwrite_i;
  logic [REG_AW-1:0]         memwb_rd_i;
  logic                      flush_i;
  logic                      clr_cnt_i;
  logic [2*NUM_SRC-1:0]      fwd_sel_o;
  logic                      pc_write_o;
  logic                      ifid_write_o;
  logic                      idex_bubble_o;
  logic                      stall_busy_o;
  logic [CNT_W-1:0]          fwd_cnt_o;
  logic [CNT_W-1:0]          stall_cnt_o;

  modport master (
    output id_src_addr_i, id_src_used_i, ex_src_addr_i, idex_memread_i, idex_rd_i,
           exmem_regwrite_i, exmem_rd_i, memwb_regwrite_i, memwb_rd_i, flush_i, clr_cnt_i,
    input  fwd_sel_o, pc_write_o, ifid_write_o, idex_bubble_o, stall_busy_o,
           fwd_cnt_o, stall_cnt_o
  );

  modport slave (
    input  id_src_addr_i, id_src_used_i, ex_src_addr_i, idex_memread_i, idex_rd_i,
           exmem_regwrite_i, exmem_rd_i, memwb_regwrite_i, memwb_rd_i, flush_i, clr_cnt_i,
    output fwd_sel_o, pc_write_o, ifid_write_o, idex_bubble_o, stall_busy_o,
           fwd_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use stall sequencing and saturating forward/stall statistics
// for the pipelined CPU.
module fwd_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fwd_hazard_unit_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_e;

  state_e               state_q;
  logic [2:0]           rem_q;
  logic                 busy_q;
  logic [2*NUM_SRC-1:0] fwdSel;
  logic                 anyFwd;
  logic                 loadUseHit;
  logic                 stall;
  logic [CNT_W-1:0]     fwdCnt_q, fwdCnt_d;
  logic [CNT_W-1:0]     stallCnt_q, stallCnt_d;

  always_comb begin
    fwdSel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.exmem_regwrite_i && (bus.exmem_rd_i != '0) &&
          (bus.exmem_rd_i == bus.ex_src_addr_i[k*REG_AW +: REG_AW])) begin
        fwdSel[2*k +: 2] = 2'b10;
      end else if (bus.memwb_regwrite_i && (bus.memwb_rd_i != '0) &&
                   (bus.memwb_rd_i == bus.ex_src_addr_i[k*REG_AW +: REG_AW])) begin
        fwdSel[2*k +: 2] = 2'b01;
      end
    end
  end

  assign anyFwd = |fwdSel;

  always_comb begin
    loadUseHit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.id_src_used_i[k] && (bus.id_src_addr_i[k*REG_AW +: REG_AW] == bus.idex_rd_i)) begin
        loadUseHit = 1'b1;
      end
    end
    if (!bus.idex_memread_i || (bus.idex_rd_i == '0)) begin
      loadUseHit = 1'b0;
    end
  end

  // Reset gates the stall so the pipeline enables release without waiting for an edge.
  assign stall = !rst_i && !bus.flush_i &&
                 (((state_q == IDLE) && loadUseHit) || (state_q == STALL));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((LOAD_STALL > 1) && loadUseHit && !bus.flush_i) begin
            state_q <= STALL;
            rem_q   <= 3'(LOAD_STALL - 1);
            busy_q  <= 1'b1;
          end
        end
        STALL: begin
          if (bus.flush_i || (rem_q <= 3'd1)) begin
            state_q <= IDLE;
            rem_q   <= 3'd0;
            busy_q  <= 1'b0;
          end else begin
            rem_q <= rem_q - 3'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          rem_q   <= 3'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    fwdCnt_d   = fwdCnt_q;
    stallCnt_d = stallCnt_q;
    if (bus.clr_cnt_i) begin
      fwdCnt_d   = '0;
      stallCnt_d = '0;
    end else begin
      if (anyFwd && (fwdCnt_q != '1)) begin
        fwdCnt_d = fwdCnt_q + 1'b1;
      end
      if (stall && (stallCnt_q != '1)) begin
        stallCnt_d = stallCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fwdCnt_q   <= '0;
      stallCnt_q <= '0;
    end else begin
      fwdCnt_q   <= fwdCnt_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign bus.fwd_sel_o     = fwdSel;
  assign bus.pc_write_o    = !stall;
  assign bus.ifid_write_o  = !stall;
  assign bus.idex_bubble_o = stall;
  assign bus.stall_busy_o  = busy_q;
  assign bus.fwd_cnt_o     = fwdCnt_q;
  assign bus.stall_cnt_o   = stallCnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances (LOAD_STALL=1/CNT_W=4 and LOAD_STALL=3/CNT_W=16)
// share one stimulus; per-cycle expectations go through a queue and are popped at the negedge.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] idSrcAddr;
  logic [1:0] idSrcUsed;
  logic [9:0] exSrcAddr;
  logic       idexMemread;
  logic [4:0] idexRd;
  logic       exmemRegwrite;
  logic [4:0] exmemRd;
  logic       memwbRegwrite;
  logic [4:0] memwbRd;
  logic       flush;
  logic       clrCnt;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct packed {
    logic [3:0] fwdA;
    logic [2:0] ctlA;
    logic       busyA;
    logic [3:0] fwdB;
    logic [2:0] ctlB;
    logic       busyB;
  } obs_t;

  obs_t expQ[$];
  obs_t got, want;

  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(4))  busA ();
  fwd_hazard_unit_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(16)) busB ();

  assign busA.id_src_addr_i    = idSrcAddr;
  assign busA.id_src_used_i    = idSrcUsed;
  assign busA.ex_src_addr_i    = exSrcAddr;
  assign busA.idex_memread_i   = idexMemread;
  assign busA.idex_rd_i        = idexRd;
  assign busA.exmem_regwrite_i = exmemRegwrite;
  assign busA.exmem_rd_i       = exmemRd;
  assign busA.memwb_regwrite_i = memwbRegwrite;
  assign busA.memwb_rd_i       = memwbRd;
  assign busA.flush_i          = flush;
  assign busA.clr_cnt_i        = clrCnt;

  assign busB.id_src_addr_i    = idSrcAddr;
  assign busB.id_src_used_i    = idSrcUsed;
  assign busB.ex_src_addr_i    = exSrcAddr;
  assign busB.idex_memread_i   = idexMemread;
  assign busB.idex_rd_i        = idexRd;
  assign busB.exmem_regwrite_i = exmemRegwrite;
  assign busB.exmem_rd_i       = exmemRd;
  assign busB.memwb_regwrite_i = memwbRegwrite;
  assign busB.memwb_rd_i       = memwbRd;
  assign busB.flush_i          = flush;
  assign busB.clr_cnt_i        = clrCnt;

  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_STALL(1), .CNT_W(4)) dutA (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (busA.slave)
  );

  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_STALL(3), .CNT_W(16)) dutB (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (busB.slave)
  );

  function automatic obs_t observe();
    obs_t o;
    o.fwdA  = busA.fwd_sel_o;
    o.ctlA  = {busA.pc_write_o, busA.ifid_write_o, busA.idex_bubble_o};
    o.busyA = busA.stall_busy_o;
    o.fwdB  = busB.fwd_sel_o;
    o.ctlB  = {busB.pc_write_o, busB.ifid_write_o, busB.idex_bubble_o};
    o.busyB = busB.stall_busy_o;
    return o;
  endfunction

  // Stall s maps to {pc_write, ifid_write, bubble} = {!s, !s, s}.
  function automatic obs_t expect_of(logic [3:0] fwd, logic sA, logic bA, logic sB, logic bB);
    obs_t e;
    e.fwdA  = fwd;
    e.ctlA  = {~sA, ~sA, sA};
    e.busyA = bA;
    e.fwdB  = fwd;
    e.ctlB  = {~sB, ~sB, sB};
    e.busyB = bB;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    idSrcAddr = '0; idSrcUsed = '0; exSrcAddr = '0;
    idexMemread = 1'b0; idexRd = '0;
    exmemRegwrite = 1'b0; exmemRd = '0;
    memwbRegwrite = 1'b0; memwbRd = '0;
    flush = 1'b0; clrCnt = 1'b0;
  endtask

  task automatic clear_counters();
    clear_inputs();
    clrCnt = 1'b1;
    tick();
    clrCnt = 1'b0;
  endtask

  task automatic set_hit(input logic useOp1);
    idexMemread = 1'b1;
    idexRd      = 5'd5;
    idSrcAddr   = useOp1 ? {5'd5, 5'd0} : {5'd0, 5'd5};
    idSrcUsed   = useOp1 ? 2'b10 : 2'b01;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    expQ.push_back(expect_of(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
    got = observe(); want = expQ.pop_front();
    checkCount++;
    if (got !== want) $display("[TB] FAIL reset_outputs: observed %h, expected %h", got, want);
    else passCount++;
    checkCount++;
    if ({busA.fwd_cnt_o, busA.stall_cnt_o, busB.fwd_cnt_o, busB.stall_cnt_o} !== 40'd0)
      $display("[TB] FAIL reset_counters: observed %h %h %h %h, expected all 0",
               busA.fwd_cnt_o, busA.stall_cnt_o, busB.fwd_cnt_o, busB.stall_cnt_o);
    else passCount++;
    exmemRegwrite = 1'b1; exmemRd = 5'd3; exSrcAddr = {5'd0, 5'd3};
    #1;
    expQ.push_back(expect_of(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0));
    got = observe(); want = expQ.pop_front();
    checkCount++;
    if (got !== want) $display("[TB] FAIL reset_fwd_comb: observed %h, expected %h", got, want);
    else passCount++;
    tick();
    tick();
    checkCount++;
    if ({busA.fwd_cnt_o, busB.fwd_cnt_o} !== 20'd0)
      $display("[TB] FAIL reset_hold_cnt: observed %h %h, expected 0 0", busA.fwd_cnt_o, busB.fwd_cnt_o);
    else passCount++;
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_fwd_priority();
    logic [3:0] expFwd [4] = '{4'b0010, 4'b0001, 4'b0110, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      exSrcAddr = {5'd4, 5'd3};
      exmemRd   = 5'd3;
      memwbRd   = (i == 2) ? 5'd4 : 5'd3;
      exmemRegwrite = (i == 0) || (i == 2);
      memwbRegwrite = (i != 3);
      expQ.push_back(expect_of(expFwd[i], 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      got = observe(); want = expQ.pop_front();
      checkCount++;
      if (got !== want) $display("[TB] FAIL fwd_priority cycle %0d: observed %h, expected %h", i, got, want);
      else passCount++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reg_zero();
    clear_counters();
    exmemRegwrite = 1'b1; exmemRd = 5'd0;
    memwbRegwrite = 1'b1; memwbRd = 5'd0;
    exSrcAddr = '0;
    expQ.push_back(expect_of(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    got = observe(); want = expQ.pop_front();
    checkCount++;
    if (got !== want) $display("[TB] FAIL reg_zero_sel: observed %h, expected %h", got, want);
    else passCount++;
    tick();
    clear_inputs();
    @(negedge clk);
    checkCount++;
    if ({busA.fwd_cnt_o, busB.fwd_cnt_o} !== 20'd0)
      $display("[TB] FAIL reg_zero_cnt: observed %h %h, expected 0 0", busA.fwd_cnt_o, busB.fwd_cnt_o);
    else passCount++;
    tick();
  endtask

  task automatic test_load_use();
    // Per cycle {stallA, busyA, stallB, busyB}.
    logic [3:0] exp [10] = '{4'b1010, 4'b0011, 4'b0011, 4'b0000, 4'b0000,
                             4'b0000, 4'b1010, 4'b0011, 4'b0011, 4'b0000};
    clear_counters();
    for (int i = 0; i < 10; i++) begin
      clear_inputs();
      case (i)
        0: set_hit(1'b0);
        4: begin set_hit(1'b0); idSrcUsed = 2'b00; end
        5: begin idexMemread = 1'b1; idexRd = 5'd0; idSrcAddr = '0; idSrcUsed = 2'b11; end
        6: set_hit(1'b1);
        default: ;
      endcase
      expQ.push_back(expect_of(4'b0000, exp[i][3], exp[i][2], exp[i][1], exp[i][0]));
      @(negedge clk);
      got = observe(); want = expQ.pop_front();
      checkCount++;
      if (got !== want) $display("[TB] FAIL load_use cycle %0d: observed %h, expected %h", i, got, want);
      else passCount++;
      if (i == 3) begin
        checkCount++;
        if (busA.stall_cnt_o !== 4'd1 || busB.stall_cnt_o !== 16'd3)
          $display("[TB] FAIL load_use_stall_cnt: observed %0d %0d, expected 1 3",
                   busA.stall_cnt_o, busB.stall_cnt_o);
        else passCount++;
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_flush();
    logic [3:0] exp [5] = '{4'b1010, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    clear_counters();
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      if (i == 0 || i == 3) set_hit(1'b0);
      if (i == 1 || i == 3) flush = 1'b1;
      expQ.push_back(expect_of(4'b0000, exp[i][3], exp[i][2], exp[i][1], exp[i][0]));
      @(negedge clk);
      got = observe(); want = expQ.pop_front();
      checkCount++;
      if (got !== want) $display("[TB] FAIL flush cycle %0d: observed %h, expected %h", i, got, want);
      else passCount++;
      tick();
    end
    clear_inputs();
    @(negedge clk);
    checkCount++;
    if (busA.stall_cnt_o !== 4'd1 || busB.stall_cnt_o !== 16'd1)
      $display("[TB] FAIL flush_stall_cnt: observed %0d %0d, expected 1 1",
               busA.stall_cnt_o, busB.stall_cnt_o);
    else passCount++;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    clear_counters();
    set_hit(1'b0);
    tick();
    clear_inputs();
    expQ.push_back(expect_of(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1));
    @(negedge clk);
    got = observe(); want = expQ.pop_front();
    checkCount++;
    if (got !== want) $display("[TB] FAIL mid_stall_pre: observed %h, expected %h", got, want);
    else passCount++;
    #2;
    rst = 1'b1;
    set_hit(1'b0);
    #1;
    expQ.push_back(expect_of(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
    got = observe(); want = expQ.pop_front();
    checkCount++;
    if (got !== want) $display("[TB] FAIL mid_stall_async_rst: observed %h, expected %h", got, want);
    else passCount++;
    checkCount++;
    if (busB.stall_cnt_o !== 16'd0)
      $display("[TB] FAIL mid_stall_rst_cnt: observed %0d, expected 0", busB.stall_cnt_o);
    else passCount++;
    tick();
    rst = 1'b0;
    clear_inputs();
    expQ.push_back(expect_of(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    got = observe(); want = expQ.pop_front();
    checkCount++;
    if (got !== want) $display("[TB] FAIL mid_stall_post: observed %h, expected %h", got, want);
    else passCount++;
    tick();
  endtask

  task automatic test_saturation();
    clear_counters();
    for (int i = 0; i < 20; i++) begin
      exmemRegwrite = 1'b1; exmemRd = 5'd3; exSrcAddr = {5'd0, 5'd3};
      expQ.push_back(expect_of(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      got = observe(); want = expQ.pop_front();
      checkCount++;
      if (got !== want) $display("[TB] FAIL saturation_sel cycle %0d: observed %h, expected %h", i, got, want);
      else passCount++;
      tick();
    end
    clear_inputs();
    @(negedge clk);
    checkCount++;
    if (busA.fwd_cnt_o !== 4'd15 || busB.fwd_cnt_o !== 16'd20)
      $display("[TB] FAIL saturation_cnt: observed %0d %0d, expected 15 20", busA.fwd_cnt_o, busB.fwd_cnt_o);
    else passCount++;
    tick();
  endtask

  task automatic test_clear_concurrent();
    clear_inputs();
    clrCnt = 1'b1;
    exmemRegwrite = 1'b1; exmemRd = 5'd3; exSrcAddr = {5'd0, 5'd3};
    set_hit(1'b0);
    expQ.push_back(expect_of(4'b0010, 1'b1, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    got = observe(); want = expQ.pop_front();
    checkCount++;
    if (got !== want) $display("[TB] FAIL clear_event: observed %h, expected %h", got, want);
    else passCount++;
    tick();
    clear_inputs();
    @(negedge clk);
    checkCount++;
    if ({busA.fwd_cnt_o, busA.stall_cnt_o, busB.fwd_cnt_o, busB.stall_cnt_o} !== 40'd0)
      $display("[TB] FAIL clear_priority: observed %h %h %h %h, expected all 0",
               busA.fwd_cnt_o, busA.stall_cnt_o, busB.fwd_cnt_o, busB.stall_cnt_o);
    else passCount++;
    tick();
    tick();
    @(negedge clk);
    checkCount++;
    if (busA.stall_cnt_o !== 4'd0 || busB.stall_cnt_o !== 16'd2)
      $display("[TB] FAIL clear_then_count: observed %0d %0d, expected 0 2",
               busA.stall_cnt_o, busB.stall_cnt_o);
    else passCount++;
    tick();
  endtask

  initial begin
    $display("[TB] starting fwd_hazard_unit bench");
    test_reset();
    test_fwd_priority();
    test_reg_zero();
    test_load_use();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    test_clear_concurrent();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
